// File: rtl/adder_rr_arbiter_if.sv
// Requester/consumer bundle for adder_rr_arbiter; master = environment, slave = arbiter.
// sat_flag exists only when ADDER_RR_ARB_SAT_EN is defined.
interface adder_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         res_sum;
  logic                      res_carry;
  logic [ID_W-1:0]           res_id;
  logic [7:0]                grant_cnt;
`ifdef ADDER_RR_ARB_SAT_EN
  logic                      sat_flag;

  modport master (output req_valid, req_a, req_b, res_ready,
                  input  req_ready, res_valid, res_sum, res_carry, res_id, grant_cnt, sat_flag);
  modport slave  (input  req_valid, req_a, req_b, res_ready,
                  output req_ready, res_valid, res_sum, res_carry, res_id, grant_cnt, sat_flag);
`else
  modport master (output req_valid, req_a, req_b, res_ready,
                  input  req_ready, res_valid, res_sum, res_carry, res_id, grant_cnt);
  modport slave  (input  req_valid, req_a, req_b, res_ready,
                  output req_ready, res_valid, res_sum, res_carry, res_id, grant_cnt);
`endif
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin shared adder: one grant per cycle into a single-entry result slot.
// Optional saturation on carry-out enabled by ADDER_RR_ARB_SAT_EN.
module adder_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input logic          clk,
  input logic          rst,
  adder_rr_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr;
  logic [7:0]         grant_cnt;
  logic               slot_free;
  logic [NUM_REQ-1:0] grant;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    sel;
  int unsigned        idx;
  logic [DATA_W-1:0]  a_p0, b_p0;
  logic [DATA_W:0]    sum_p0;
  logic [DATA_W-1:0]  sum_p1;
  logic               carry_p1;
  logic [ID_W-1:0]    id_p1;
  logic               vld_p1;

`ifdef ADDER_RR_ARB_SAT_EN
  logic sat_p1;

  function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W:0] raw);
    return raw[DATA_W] ? {DATA_W{1'b1}} : raw[DATA_W-1:0];
  endfunction
`endif

  assign vld_p1    = (state_q == FULL);
  assign slot_free = !vld_p1 || bus.res_ready;

  // Grant search starts at rr_ptr and wraps; operands never feed this path.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    sel     = '0;
    if (slot_free && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        sel = ID_W'(idx);
        if (!gnt_any && bus.req_valid[sel]) begin
          gnt_any    = 1'b1;
          gnt_idx    = sel;
          grant[sel] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (gnt_any) state_d = FULL;
      FULL:    if (bus.res_ready && !gnt_any) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Stage p0: operand select and add
  assign a_p0   = bus.req_a[gnt_idx*DATA_W +: DATA_W];
  assign b_p0   = bus.req_b[gnt_idx*DATA_W +: DATA_W];
  assign sum_p0 = {1'b0, a_p0} + {1'b0, b_p0};

  // Stage p1: result slot and arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      rr_ptr    <= '0;
      grant_cnt <= '0;
      sum_p1    <= '0;
      carry_p1  <= 1'b0;
      id_p1     <= '0;
`ifdef ADDER_RR_ARB_SAT_EN
      sat_p1    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
`ifdef ADDER_RR_ARB_SAT_EN
        sum_p1 <= sat_sum(sum_p0);
        sat_p1 <= sum_p0[DATA_W];
`else
        sum_p1 <= sum_p0[DATA_W-1:0];
`endif
        carry_p1  <= sum_p0[DATA_W];
        id_p1     <= gnt_idx;
        rr_ptr    <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        grant_cnt <= grant_cnt + 8'd1;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.res_valid = vld_p1;
  assign bus.res_sum   = sum_p1;
  assign bus.res_carry = carry_p1;
  assign bus.res_id    = id_p1;
  assign bus.grant_cnt = grant_cnt;
`ifdef ADDER_RR_ARB_SAT_EN
  assign bus.sat_flag  = sat_p1;
`endif
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: directed scenarios plus random traffic against a queue-free
// behavioural model of the arbitration and slot rules.
module tb_adder_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = $clog2(NUM_REQ);
`ifdef ADDER_RR_ARB_SAT_EN
  localparam int SATW = 1;
`else
  localparam int SATW = 0;
`endif
  localparam int VW = NUM_REQ + 1 + DATA_W + 1 + ID_W + 8 + SATW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();
  adder_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_ptr = 0, m_cnt = 0, m_sum = 0, m_carry = 0, m_id = 0, m_sat = 0;
  bit m_valid = 1'b0;

  function automatic int exp_grant();
    int idx;
    if (rst) return -1;
    if (m_valid && !bus.res_ready) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NUM_REQ-1:0] rdy;
    int g;
    rdy = '0;
    g = exp_grant();
    if (g >= 0) rdy[g] = 1'b1;
`ifdef ADDER_RR_ARB_SAT_EN
    return {rdy, m_valid, DATA_W'(m_sum), 1'(m_carry), ID_W'(m_id), 8'(m_cnt), 1'(m_sat)};
`else
    return {rdy, m_valid, DATA_W'(m_sum), 1'(m_carry), ID_W'(m_id), 8'(m_cnt)};
`endif
  endfunction

  function automatic logic [VW-1:0] act_vec();
`ifdef ADDER_RR_ARB_SAT_EN
    return {bus.req_ready, bus.res_valid, bus.res_sum, bus.res_carry, bus.res_id, bus.grant_cnt, bus.sat_flag};
`else
    return {bus.req_ready, bus.res_valid, bus.res_sum, bus.res_carry, bus.res_id, bus.grant_cnt};
`endif
  endfunction

  task automatic model_edge();
    int g, a, b, s;
    g = exp_grant();
    if (rst) begin
      m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0; m_ptr = 0; m_sat = 0;
    end else if (g >= 0) begin
      a = int'(bus.req_a[g*DATA_W +: DATA_W]);
      b = int'(bus.req_b[g*DATA_W +: DATA_W]);
      s = a + b;
      m_sum   = s % (1 << DATA_W);
      m_carry = s >> DATA_W;
      m_sat   = 0;
`ifdef ADDER_RR_ARB_SAT_EN
      if (m_carry != 0) begin
        m_sum = (1 << DATA_W) - 1;
        m_sat = 1;
      end
`endif
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NUM_REQ;
      m_cnt   = (m_cnt + 1) % 256;
    end else if (m_valid && bus.res_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    bus.req_a = '0;
    bus.req_b = '0;
    cycle();
    cycle();
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b0 || bus.grant_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state rdy=%b vld=%b cnt=%0d required 0000/0/0", bus.req_ready, bus.res_valid, bus.grant_cnt);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant rdy=%b required 0001", bus.req_ready);
    end
    cycle();
    #1;
    n_checks++;
    if (act_vec() !== exp_vec() || bus.res_id !== 2'd0 || bus.res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_result act=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    cycle();
    bus.req_valid = 4'b0100;
    set_op(2, 8'h12, 8'h34);
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready rdy=%b required 0100", bus.req_ready);
    end
    cycle();
    bus.req_valid = '0;
    #1;
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h46 || bus.res_carry !== 1'b0 ||
        bus.res_id !== 2'd2 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_result vld=%b sum=%h c=%b id=%0d rdy=%b required 1/46/0/2/0000",
               bus.res_valid, bus.res_sum, bus.res_carry, bus.res_id, bus.req_ready);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op(i % NUM_REQ, 8'($urandom), 8'($urandom));
      cycle();
      #1;
      n_checks++;
      if (bus.res_id !== ID_W'(i % NUM_REQ) || act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rr_order step=%0d id=%0d required %0d act=%h exp=%h",
                 i, bus.res_id, i % NUM_REQ, act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.grant_cnt !== 8'd8) begin
      n_fail++;
      $display("FAIL rr_grant_cnt cnt=%0d required 8", bus.grant_cnt);
    end
  endtask

  task automatic test_backpressure();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    cycle();
    bus.req_valid = 4'b0001;
    set_op(0, 8'h05, 8'h05);
    cycle();
    bus.req_valid = 4'b0010;
    set_op(1, 8'h01, 8'h02);
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000 || bus.res_sum !== 8'h0A || bus.res_valid !== 1'b1 ||
          bus.res_id !== 2'd0 || act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d rdy=%b sum=%h vld=%b id=%0d required 0000/0a/1/0",
                 i, bus.req_ready, bus.res_sum, bus.res_valid, bus.res_id);
      end
      cycle();
    end
    bus.res_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release_ready rdy=%b required 0010", bus.req_ready);
    end
    cycle();
    bus.res_ready = 1'b0;
    bus.req_valid = '0;
    #1;
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 || bus.res_sum !== 8'h03) begin
      n_fail++;
      $display("FAIL bp_release_result vld=%b id=%0d sum=%h required 1/1/03",
               bus.res_valid, bus.res_id, bus.res_sum);
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] want1, want0;
`ifdef ADDER_RR_ARB_SAT_EN
    want1 = 8'hFF;
    want0 = 8'hFF;
`else
    want1 = 8'h01;
    want0 = 8'h00;
`endif
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1000;
    set_op(3, 8'hFF, 8'h02);
    cycle();
    #1;
    n_checks++;
    if (bus.res_sum !== want1 || bus.res_carry !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL overflow_ff_02 sum=%h c=%b required %h/1", bus.res_sum, bus.res_carry, want1);
    end
    set_op(3, 8'hFF, 8'h01);
    cycle();
    bus.req_valid = '0;
    #1;
    n_checks++;
    if (bus.res_sum !== want0 || bus.res_carry !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL overflow_ff_01 sum=%h c=%b required %h/1", bus.res_sum, bus.res_carry, want0);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0010;
    cycle();
    bus.res_ready = 1'b0;
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_pre vld=%b rdy=%b required 1/0000", bus.res_valid, bus.req_ready);
    end
    cycle();
    #1;
    n_checks++;
    if (bus.res_valid !== 1'b0 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL midrst_discard vld=%b required 0 act=%h exp=%h", bus.res_valid, act_vec(), exp_vec());
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_first_grant rdy=%b required 0001", bus.req_ready);
    end
    cycle();
  endtask

  task automatic test_cnt_wrap();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 260; i++) cycle();
    #1;
    n_checks++;
    if (bus.grant_cnt !== 8'd4 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL cnt_wrap cnt=%0d required 4", bus.grant_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.req_valid = NUM_REQ'($urandom);
      bus.req_a     = (NUM_REQ*DATA_W)'($urandom);
      bus.req_b     = (NUM_REQ*DATA_W)'($urandom);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 99) == 0);
      #1;
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random step=%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_cnt_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one registered DATA_W-bit adder between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin arbiter grants at most one requester per cycle. The granted sum is registered into a single-entry output slot, tagged with the requester ID, and drained through a valid/ready result port.
- Sits between the top-level pin mapping and the adder datapath; it sequences all use of the adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, operand and sum width
- ID_W, $clog2(NUM_REQ), width of the requester ID (derived; not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  operand B, same packing as req_a
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs on req_valid[i] & req_ready[i]
- res_valid  out  1  output slot holds a result
- res_ready  in  1  consumer accepts the result
- res_sum  out  DATA_W  registered sum, low DATA_W bits
- res_carry  out  1  carry-out of the registered sum
- res_id  out  ID_W  index of the requester that produced the result
- grant_cnt  out  8  total accepted transfers since reset, wraps 255->0

Behaviour:
- Reset (rst=1 at a clock edge):
  - res_valid=0, res_sum=0, res_carry=0, res_id=0, grant_cnt=0, rr_ptr=0.
  - req_ready is 0 while rst=1.
- Slot FSM, two states:
  - EMPTY (res_valid=0) -> FULL on a grant.
  - FULL (res_valid=1):
    - res_valid & res_ready & grant -> stays FULL with new contents (back-to-back).
    - res_valid & res_ready & no grant -> EMPTY.
    - otherwise holds FULL.
- slot_free = !res_valid | res_ready (combinational). This is the only ready path from consumer to requester.
- Arbitration (combinational):
  - When slot_free, search req_valid starting at rr_ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - The first set bit i gets req_ready[i]=1; all other bits are 0.
  - No request, or !slot_free -> req_ready all 0.
  - req_ready must not depend on req_a or req_b.
- On a grant to requester i at edge t:
  - res_sum/res_carry <= {1'b0,req_a[i]} + {1'b0,req_b[i]}.
  - res_id <= i; res_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - grant_cnt <= grant_cnt+1.
- No grant -> rr_ptr unchanged.
- Latency: the result is visible the cycle after acceptance. Throughput is 1 per cycle while res_ready=1.
- Backpressure: while res_valid & !res_ready, res_sum, res_carry and res_id are held stable.
- Requester side: a requester may deassert req_valid without a grant, and the arbiter must tolerate this.
- Fairness: with all requesters continuously valid, grants follow 0,1,...,NUM_REQ-1,0,... Each requester waits at most NUM_REQ-1 grants.
- Wrap-around: 0xFF+0x01 (DATA_W=8) -> res_sum=0x00, res_carry=1.
- Reset mid-operation: a pending result is discarded (res_valid=0 the next cycle) and rr_ptr returns to 0.

Optional Feature:
- Macro ADDER_RR_ARB_SAT_EN.
- Defined:
  - On carry-out, res_sum is forced to all ones (0xFF for DATA_W=8).
  - res_carry still reports the raw carry.
  - Adds output sat_flag (1 bit): registered with the result, reset 0, high when saturation applied.
- Undefined:
  - Modular sum as specified above.
  - No sat_flag port.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, res_valid=0, grant_cnt=0; release -> first grant to requester 0.
- Single requester: req 2 presents a=0x12, b=0x34, res_ready=1 -> req_ready=4'b0100 for one cycle; next cycle res_valid=1, res_sum=0x46, res_carry=0, res_id=2.
- Round-robin: all 4 valid and res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3; grant_cnt=8.
- Backpressure: result 0x0A pending, res_ready=0 for 3 cycles with req 1 valid -> req_ready=0 and outputs stable; raise res_ready -> req 1 granted that cycle and its result appears the next cycle.
- Overflow: a=0xFF, b=0x02 -> res_sum=0x01, res_carry=1. With ADDER_RR_ARB_SAT_EN: res_sum=0xFF, sat_flag=1.
- Reset mid-operation: assert rst while res_valid=1 and rr_ptr=2 -> next cycle res_valid=0; after release, the first grant goes to requester 0.
